// File: rtl/i2c_slave_fifo_bridge.sv
// Byte bridge between the i2c_slave byte interface and host RX/TX streams.
// Build option: define I2C_BRIDGE_IDLE_BYTE_EN to answer TX underrun with IDLE_BYTE instead of waiting.
// state    | meaning
// SRV_IDLE | waiting for data_req with a byte to hand over
// SRV_TICK | rd_tick high this cycle; data_req ignored while the slave clears it
module i2c_slave_fifo_bridge #(
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data_wrt,
  input  logic                  wrt_tick,
  input  logic                  data_req,
  output logic [7:0]            data_rd,
  output logic                  rd_tick,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic                  rx_overflow,
  output logic                  tx_underrun,
  input  logic                  clr_flags
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {SRV_IDLE, SRV_TICK} srv_state_t;

  srv_state_t srv_state;

  logic [7:0]            rx_mem [DEPTH];
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic                  rx_full, tx_empty;
  logic                  rx_push, rx_pop, tx_push, tx_pop;
  logic                  data_req_q;
  logic                  underrun_set, overflow_set;

  assign rx_full  = (rx_count == CNT_FULL);
  assign rx_valid = (rx_count != '0);
  assign rx_data  = rx_mem[rx_rd_ptr];
  assign tx_empty = (tx_count == '0);
  assign tx_ready = (tx_count != CNT_FULL);

  // A full RX still accepts a byte when the host pops in the same cycle.
  assign rx_pop       = rx_valid && rx_ready;
  assign rx_push      = wrt_tick && (!rx_full || rx_pop);
  assign overflow_set = wrt_tick && rx_full && !rx_pop;
  assign tx_push      = tx_valid && tx_ready;
  assign tx_pop       = (srv_state == SRV_IDLE) && data_req && !tx_empty;

  always_comb begin
    underrun_set = data_req && !data_req_q && tx_empty;
`ifdef I2C_BRIDGE_IDLE_BYTE_EN
    if ((srv_state == SRV_IDLE) && data_req && tx_empty)
      underrun_set = 1'b1;
`endif
  end

`ifndef I2C_BRIDGE_IDLE_BYTE_EN
  logic [7:0] unused_idle_byte;
  assign unused_idle_byte = IDLE_BYTE;
`endif

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= data_wrt;
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
      data_req_q  <= 1'b0;
    end else begin
      data_req_q <= data_req;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;
      // A set event in the same cycle as clr_flags keeps the flag high.
      if (overflow_set)   rx_overflow <= 1'b1;
      else if (clr_flags) rx_overflow <= 1'b0;
      if (underrun_set)   tx_underrun <= 1'b1;
      else if (clr_flags) tx_underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srv_state <= SRV_IDLE;
      data_rd   <= 8'h00;
      rd_tick   <= 1'b0;
    end else begin
      case (srv_state)
        SRV_IDLE: begin
          if (tx_pop) begin
            data_rd   <= tx_mem[tx_rd_ptr];
            rd_tick   <= 1'b1;
            srv_state <= SRV_TICK;
`ifdef I2C_BRIDGE_IDLE_BYTE_EN
          end else if (data_req) begin
            data_rd   <= IDLE_BYTE;
            rd_tick   <= 1'b1;
            srv_state <= SRV_TICK;
`endif
          end else begin
            rd_tick <= 1'b0;
          end
        end
        SRV_TICK: begin
          rd_tick   <= 1'b0;
          srv_state <= SRV_IDLE;
        end
        default: begin
          rd_tick   <= 1'b0;
          srv_state <= SRV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_fifo_bridge.md
# i2c_slave_fifo_bridge

- Buffers bytes between the I2C slave's internal-side byte interface and a host-side streaming interface.
- Bytes written by the I2C master (`data_wrt`/`wrt_tick`) are pushed into an RX FIFO for the host.
- Bytes the host queues in a TX FIFO answer the slave's `data_req` with `data_rd`/`rd_tick`.
- Sits directly downstream of `i2c_slave`, between it and the system bus/CPU logic.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: each FIFO holds 2^DEPTH_LOG2 bytes.
- `IDLE_BYTE`, default 8'hFF: byte returned on TX underrun; used only with `I2C_BRIDGE_IDLE_BYTE_EN`.

Ports:
- `clk` in 1: single clock, shared with `i2c_slave`.
- `reset` in 1: synchronous, active-high.
- `data_wrt` in 8: byte received from the master.
- `wrt_tick` in 1: one-cycle strobe; `data_wrt` is valid.
- `data_req` in 1: level; the slave needs the next byte for the master.
- `data_rd` out 8: byte supplied to the slave.
- `rd_tick` out 1: one-cycle strobe; `data_rd` is valid.
- `rx_data` out 8: RX FIFO head byte (show-ahead).
- `rx_valid` out 1: RX FIFO is non-empty.
- `rx_ready` in 1: host pops the RX head when `rx_valid` is high.
- `tx_data` in 8: host byte to queue.
- `tx_valid` in 1: host push request.
- `tx_ready` out 1: TX FIFO is not full.
- `rx_count`, `tx_count` out DEPTH_LOG2+1: current occupancy of each FIFO.
- `rx_overflow` out 1: sticky; a byte was dropped because RX was full.
- `tx_underrun` out 1: sticky; `data_req` rose while TX was empty.
- `clr_flags` in 1: clears both sticky flags.

## Operation
- **FIFOs**: two independent circular FIFOs.
  - Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - Counts are DEPTH_LOG2+1 bits wide.
  - Full means count == 2^DEPTH_LOG2; empty means count == 0.
- **RX push**: on `wrt_tick`, write `data_wrt` at the write pointer, increment the write pointer and the count.
  - If RX is full and the host is not popping in the same cycle, drop the byte and set `rx_overflow`.
- **RX pop**: on `rx_valid && rx_ready`, advance the read pointer.
  - `rx_ready` has no effect when RX is empty.
- **RX simultaneous push + pop**: both succeed; the count is unchanged. This holds when full as well, so no overflow is flagged.
- **TX push**: on `tx_valid && tx_ready`, store `tx_data`.
  - `tx_ready` = !TX full.
  - A push on a full FIFO is impossible by handshake.
- **Serve FSM**, states SRV_IDLE and SRV_TICK:
  - **SRV_IDLE**: if `data_req` is high and TX is non-empty, load `data_rd` with the TX head, pop TX, assert `rd_tick`, and go to SRV_TICK.
  - **SRV_IDLE**: if `data_req` is high and TX is empty, wait in SRV_IDLE.
    - A later host push is served the cycle after it lands.
  - **SRV_TICK**: deassert `rd_tick` and return to SRV_IDLE.
    - `data_req` is ignored for this cycle, because the slave clears its flag one cycle after `rd_tick`.
  - **Simultaneous TX push and pop**: both succeed.
- **Data stability**: `data_rd` holds its value until the next serve.
- **`tx_underrun`**: set on the rising edge of `data_req` (registered previous value) while TX is empty.
- **Flag priority**: `clr_flags` clears both flags. A set event in the same cycle as `clr_flags` wins, so the flag stays 1.

## Timing
- **Reset**: synchronous `reset` gives, on the next edge:
  - pointers and counts = 0;
  - `rx_valid` = 0, `tx_ready` = 1;
  - `data_rd` = 0, `rd_tick` = 0;
  - `rx_overflow` = 0, `tx_underrun` = 0;
  - FSM = SRV_IDLE.
- **Reset mid-operation**: any pending `rd_tick` or buffered data is discarded.
- **RX latency**: `wrt_tick` sampled at edge E gives `rx_valid` and `rx_count` updated after E.
  - `rx_data` is the combinational read of the head entry.
- **TX latency**: `data_req` high with TX non-empty at edge E gives `rd_tick` = 1 and `data_rd` valid for exactly one cycle after E.
- **Serve rate**: at most one `rd_tick` per two cycles.
- **Counts**: `rx_count`/`tx_count` are registered and reflect all pushes/pops up to the last edge.

## Configuration
- Macro: `I2C_BRIDGE_IDLE_BYTE_EN`.
- **Defined**: when `data_req` is high in SRV_IDLE and TX is empty:
  - respond immediately with `data_rd` = `IDLE_BYTE` and `rd_tick`;
  - set `tx_underrun`;
  - TX is not popped.
- **Undefined**: wait for data as described in Operation; `IDLE_BYTE` is unused.

## Test plan
- **RX basic**: `reset`, then `wrt_tick` with 8'hA5, then 8'h3C (`rx_ready` = 0) -> `rx_count` = 2, `rx_data` = 8'hA5; pop once -> `rx_data` = 8'h3C, `rx_count` = 1.
- **RX overflow**: DEPTH_LOG2 = 3, push 9 bytes 8'h00..8'h08 with no pops -> `rx_count` = 8, `rx_overflow` = 1, popped sequence 00..07; `clr_flags` -> `rx_overflow` = 0.
- **TX serve**: host pushes 8'h5A, 8'hC3; hold `data_req` high for one cycle after each `rd_tick` (mimicking the slave) -> two single-cycle `rd_tick` pulses with `data_rd` = 5A then C3, no duplicate tick, `tx_count` = 0.
- **TX underrun**: `data_req` rises with TX empty -> `tx_underrun` = 1.
  - Macro undefined: no `rd_tick`; push 8'h77 three cycles later -> `rd_tick` with 8'h77 one cycle after the push.
  - Macro defined: `rd_tick` with 8'hFF the next cycle.
- **Wrap + simultaneous**: fill RX to 8, then push and pop in the same cycle for 20 cycles -> count stays 8, no overflow, FIFO order preserved across pointer wrap.
- **Reset mid-operation**: assert `reset` while in SRV_TICK with 3 bytes in each FIFO -> next cycle all counts 0, `rd_tick` = 0, `data_rd` = 0, flags 0.
